// File: rtl/adc_capture_pkg.sv
// Shared types and default sizes for the ADC A-line capture block.
package adc_capture_pkg;

  // Capture sequencing: wait for arm, wait for sweep edge, fill RAM, hand out samples.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;

  localparam int ADC_W_DEFAULT    = 14;
  localparam int OUT_W_DEFAULT    = 16;
  localparam int ADDR_W_DEFAULT   = 10;
  localparam int LINE_LEN_DEFAULT = 1024;

endpackage

// File: rtl/adc_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
// No reset on the array or read register so the tools map it onto block RAM.
module adc_line_ram
  import adc_capture_pkg::*;
#(
  parameter int ADC_W  = ADC_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADC_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [ADC_W-1:0]  rdata
);

  logic [ADC_W-1:0] mem [2**ADDR_W];

  // Write port: store a sample when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: one cycle of latency from raddr to rdata.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_line_capture.sv
// Captures one A-line of ADC samples after an armed sweep edge, then presents
// the samples one at a time to the PIO as the host steps with rd_next.
//
// Handshake: arm and rd_next are single-cycle pulses sampled on the rising
// clock edge. A sample is accepted only in a cycle where adc_valid is high and
// the block is in CAPTURE. rd_next is accepted only while line_ready is high;
// the selected sample is on data_out (with rd_index) two cycles later.
module adc_line_capture
  import adc_capture_pkg::*;
#(
  parameter int ADC_W    = ADC_W_DEFAULT,
  parameter int OUT_W    = OUT_W_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int LINE_LEN = LINE_LEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              sweep_trig,
  input  logic              adc_valid,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              rd_next,
  output logic [OUT_W-1:0]  data_out,
  output logic              line_ready,
  output logic              busy,
  output logic              overrun,
  output logic [ADDR_W-1:0] rd_index,
  output logic [1:0]        debug_state
);

  // Terminal address; LINE_LEN = 2**ADDR_W still fits because we compare
  // against LINE_LEN-1 rather than letting the counter wrap.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t             state;
  logic               trig_q;
  logic               trig_edge;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               ro_wait;
  logic               ram_we;
  logic               out_load;
  logic [ADC_W-1:0]   ram_rdata;

  assign trig_edge   = sweep_trig & ~trig_q;
  assign ram_we      = (state == CAPTURE) && adc_valid;
  assign debug_state = state;

  // The read pipeline is primed once ro_wait is set; from then on data_out
  // and rd_index track the RAM output two cycles behind rd_addr.
  assign out_load = (state == READOUT) && (ro_wait || line_ready);

  // Delay the sweep level by one cycle for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= sweep_trig;
    end
  end

  // Capture sequencer with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_addr    <= '0;
      rd_addr    <= '0;
      ro_wait    <= 1'b0;
      line_ready <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // arm wins over a coincident edge: the edge is dropped, overrun cleared.
          if (arm) begin
            state   <= ARMED;
            busy    <= 1'b1;
            overrun <= 1'b0;
          end else if (trig_edge) begin
            overrun <= 1'b1;
          end
        end
        ARMED: begin
          // The edge cycle's own sample is not written: CAPTURE starts next cycle.
          if (trig_edge) begin
            state   <= CAPTURE;
            wr_addr <= '0;
          end
        end
        CAPTURE: begin
          if (adc_valid) begin
            wr_addr <= wr_addr + ADDR_ONE;
            if (wr_addr == LAST_ADDR) begin
              state      <= READOUT;
              busy       <= 1'b0;
              rd_addr    <= '0;
              ro_wait    <= 1'b0;
              line_ready <= 1'b0;
            end
          end
        end
        READOUT: begin
          if (trig_edge) begin
            overrun <= 1'b1;
          end
          if (!line_ready) begin
            // Two cycles to push sample 0 through RAM and output registers.
            if (ro_wait) begin
              line_ready <= 1'b1;
            end else begin
              ro_wait <= 1'b1;
            end
          end else if (rd_next) begin
            if (rd_addr == LAST_ADDR) begin
              state      <= IDLE;
              line_ready <= 1'b0;
            end else begin
              rd_addr <= rd_addr + ADDR_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output stage: register RAM data (zero-extended) and its matching index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_q <= '0;
      data_out  <= '0;
      rd_index  <= '0;
    end else begin
      rd_addr_q <= rd_addr;
      if (out_load) begin
        data_out <= OUT_W'(ram_rdata);
        rd_index <= rd_addr_q;
      end
    end
  end

  adc_line_ram #(
    .ADC_W  (ADC_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (adc_data),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

endmodule
